// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: column drive, 2-flop row synchronizer, press/release debounce.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module keypad_scanner_4x4 #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_TICKS   = 32
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       ScanEnable,
  input  logic [3:0] Rows,
  output logic [3:0] Cols,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  output logic       KeyHeld
);

  if (DEBOUNCE_TICKS < 2 || DEBOUNCE_TICKS > 15) begin : g_db_range
    $error("DEBOUNCE_TICKS out of range 2..15");
  end
  if (REPEAT_TICKS < 2 || REPEAT_TICKS > 255) begin : g_rpt_range
    $error("REPEAT_TICKS out of range 2..255");
  end

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HOLD, REL_DB} state_t;

  state_t     state, state_nxt;
  logic [3:0] rows_meta, rows_sync;
  logic [3:0] cap_pat, cap_pat_nxt;
  logic [1:0] cap_row, cap_row_nxt;
  logic [1:0] col_idx, col_nxt;
  logic [1:0] row_idx;
  logic [3:0] cnt, cnt_nxt;
  logic       active, all_high;
  logic       accept, release_done, repeat_hit;
  logic [3:0] cols_nxt, code_nxt;
  logic       valid_nxt, held_nxt;

  assign all_high = &rows_sync;
  assign active   = ~all_high;

  // Lowest-index low row wins when several rows are pulled down.
  always_comb begin
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!rows_sync[i]) row_idx = 2'(i);
  end

  // State register and registered outputs
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rows_meta <= 4'hF;
      rows_sync <= 4'hF;
      state     <= SCAN;
      col_idx   <= 2'd0;
      cnt       <= 4'd0;
      cap_pat   <= 4'hF;
      cap_row   <= 2'd0;
      Cols      <= 4'b1110;
      KeyCode   <= 4'd0;
      KeyValid  <= 1'b0;
      KeyHeld   <= 1'b0;
    end else begin
      rows_meta <= Rows;
      rows_sync <= rows_meta;
      state     <= state_nxt;
      col_idx   <= col_nxt;
      cnt       <= cnt_nxt;
      cap_pat   <= cap_pat_nxt;
      cap_row   <= cap_row_nxt;
      Cols      <= cols_nxt;
      KeyCode   <= code_nxt;
      KeyValid  <= valid_nxt;
      KeyHeld   <= held_nxt;
    end
  end

  // Next-state logic; every decision is gated by a scan tick.
  always_comb begin
    state_nxt    = state;
    col_nxt      = col_idx;
    cnt_nxt      = cnt;
    cap_pat_nxt  = cap_pat;
    cap_row_nxt  = cap_row;
    accept       = 1'b0;
    release_done = 1'b0;
    if (ScanEnable) begin
      case (state)
        SCAN: begin
          if (active) begin
            cap_pat_nxt = rows_sync;
            cap_row_nxt = row_idx;
            cnt_nxt     = 4'd1;
            state_nxt   = PRESS_DB;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end
        PRESS_DB: begin
          // cap_pat always has a low bit, so all-high also lands in the mismatch branch.
          if (rows_sync == cap_pat) begin
            if (cnt == DB_LAST) begin
              accept    = 1'b1;
              cnt_nxt   = 4'd0;
              state_nxt = HOLD;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end else begin
            cnt_nxt   = 4'd0;
            state_nxt = SCAN;
          end
        end
        HOLD: begin
          if (all_high) begin
            cnt_nxt   = 4'd1;
            state_nxt = REL_DB;
          end
        end
        REL_DB: begin
          if (all_high) begin
            if (cnt == DB_LAST) begin
              release_done = 1'b1;
              cnt_nxt      = 4'd0;
              col_nxt      = col_idx + 2'd1;
              state_nxt    = SCAN;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end else begin
            cnt_nxt   = 4'd0;
            state_nxt = HOLD;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  // Output next-values
  always_comb begin
    cols_nxt  = ~(4'b0001 << col_nxt);
    code_nxt  = accept ? {cap_row, col_idx} : KeyCode;
    valid_nxt = accept | repeat_hit;
    held_nxt  = KeyHeld;
    if (accept)            held_nxt = 1'b1;
    else if (release_done) held_nxt = 1'b0;
  end

`ifdef KEY_REPEAT_EN
  localparam logic [7:0] RPT_LAST = 8'(REPEAT_TICKS - 1);
  logic [7:0] rep_cnt;
  logic       stay_hold;

  assign stay_hold  = (state == HOLD) && (state_nxt == HOLD);
  assign repeat_hit = stay_hold && ScanEnable && (rep_cnt == RPT_LAST);

  // Counts only ticks spent in HOLD; any exit, including a bounce through REL_DB, restarts it.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)                       rep_cnt <= 8'd0;
    else if (!stay_hold)              rep_cnt <= 8'd0;
    else if (ScanEnable) begin
      if (rep_cnt == RPT_LAST)        rep_cnt <= 8'd0;
      else                            rep_cnt <= rep_cnt + 8'd1;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Directed bench for keypad_scanner_4x4 with a behavioural keypad matrix model (default build).
module tb_keypad_scanner_4x4;

  logic       CLK, Reset, ScanEnable;
  logic [3:0] Rows, Cols, KeyCode;
  logic       KeyValid, KeyHeld;

  logic [3:0][3:0] pressed;  // pressed[row][col]
  int nchk = 0, nfail = 0, pulses = 0;
  logic kv_prev = 1'b0;

  keypad_scanner_4x4 dut (
    .CLK(CLK), .Reset(Reset), .ScanEnable(ScanEnable), .Rows(Rows),
    .Cols(Cols), .KeyCode(KeyCode), .KeyValid(KeyValid), .KeyHeld(KeyHeld)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // A pressed key shorts its row to its column; rows are pulled up otherwise.
  always_comb begin
    Rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !Cols[c]) Rows[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (KeyValid) begin
      pulses++;
      check("kv_one_cycle", {31'd0, kv_prev}, 32'd0);
    end
    kv_prev = KeyValid;
  end

  // One scan tick, 4 CLK apart; returns just after the tick edge so outputs reflect it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      repeat (3) @(negedge CLK);
      ScanEnable = 1'b1;
      @(negedge CLK);
      ScanEnable = 1'b0;
      #1;
    end
  endtask

  function automatic logic [3:0] col_drive(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (c % 4));
  endfunction

  typedef struct {
    int         r;
    int         c;
    int         r2;     // second simultaneous row on same column, -1 for none
    logic [3:0] code;
  } vec_t;

  vec_t vecs[4];
  int   p0;

  initial begin
    vecs[0] = '{2, 2, -1, 4'b1010};
    vecs[1] = '{1, 0,  3, 4'b0100};
    vecs[2] = '{0, 3, -1, 4'b0011};
    vecs[3] = '{2, 1,  0, 4'b0001};

    pressed = '0;
    ScanEnable = 1'b0;
    Reset = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_cols", Cols, 4'b1110);
    check("rst_code", KeyCode, 4'd0);
    check("rst_valid", KeyValid, 1'b0);
    check("rst_held", KeyHeld, 1'b0);
    Reset = 1'b1;

    // Idle scan: one column step per tick
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("idle_cols", Cols, col_drive(k));
    end
    check("idle_no_valid", pulses, 0);

    // Bounce on (1,0): 2 low ticks, 1 high, then 4 stable ticks
    pressed[1][0] = 1'b1;
    tick(2);
    pressed[1][0] = 1'b0;
    tick();
    check("bounce_col_hold", Cols, 4'b1110);
    pressed[1][0] = 1'b1;
    tick(3);
    check("bounce_no_valid_yet", pulses, 0);
    check("bounce_not_held_yet", KeyHeld, 1'b0);
    tick();
    check("bounce_one_valid", pulses, 1);
    check("bounce_held", KeyHeld, 1'b1);
    check("bounce_code", KeyCode, 4'b0100);
    tick(6);
    check("bounce_still_one", pulses, 1);
    check("bounce_cols_frozen", Cols, 4'b1110);

    // Release with a one-tick re-contact
    pressed[1][0] = 1'b0;
    tick(2);
    pressed[1][0] = 1'b1;
    tick();
    check("recontact_held", KeyHeld, 1'b1);
    pressed[1][0] = 1'b0;
    tick(3);
    check("release_3_held", KeyHeld, 1'b1);
    tick();
    check("release_done", KeyHeld, 1'b0);
    check("release_advance", Cols, 4'b1101);
    check("recontact_no_extra", pulses, 1);
    check("code_kept", KeyCode, 4'b0100);

    // Table of presses, including multi-row contacts
    for (int i = 0; i < 4; i++) begin
      p0 = pulses;
      pressed[vecs[i].r][vecs[i].c] = 1'b1;
      if (vecs[i].r2 >= 0) pressed[vecs[i].r2][vecs[i].c] = 1'b1;
      tick(10);
      check("vec_pulses", pulses - p0, 1);
      check("vec_code", KeyCode, vecs[i].code);
      check("vec_held", KeyHeld, 1'b1);
      check("vec_cols_frozen", Cols, col_drive(vecs[i].c));
      pressed = '0;
      tick(4);
      check("vec_released", KeyHeld, 1'b0);
      check("vec_cols_next", Cols, col_drive(vecs[i].c + 1));
    end

    // Reset while holding, then re-detect after reset release
    p0 = pulses;
    pressed[3][1] = 1'b1;
    tick(10);
    check("pre_rst_pulse", pulses - p0, 1);
    check("pre_rst_code", KeyCode, 4'b1101);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("midrst_cols", Cols, 4'b1110);
    check("midrst_code", KeyCode, 4'd0);
    check("midrst_valid", KeyValid, 1'b0);
    check("midrst_held", KeyHeld, 1'b0);
    @(negedge CLK);
    Reset = 1'b1;
    p0 = pulses;
    tick(8);
    check("redetect_pulse", pulses - p0, 1);
    check("redetect_code", KeyCode, 4'b1101);
    check("redetect_held", KeyHeld, 1'b1);
    pressed = '0;
    tick(4);
    check("redetect_release", KeyHeld, 1'b0);

    // No ticks: a press on the driven column must not change anything
    p0 = pulses;
    pressed[0][2] = 1'b1;
    repeat (20) @(negedge CLK);
    check("notick_held", KeyHeld, 1'b0);
    check("notick_cols", Cols, 4'b1011);
    check("notick_pulses", pulses - p0, 0);
    pressed = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner_4x4.md
Name: keypad_scanner_4x4

Overview:
- Input-side counterpart of the multiplexed 4-digit 7-segment driver: the display block drives anodes and cathodes, this block drives keypad columns and reads rows.
- Scans a 4x4 matrix keypad one column at a time, debounces press and release, and reports one key code per press.
- Scan pace comes from a ScanEnable tick, the same way the display's ContEnable paces its digit counter.
- Feeds the controller FSM so operators can enter commands (fan/alarm overrides).

Parameters:
- DEBOUNCE_TICKS, 4: consecutive ScanEnable ticks with a stable row pattern needed to accept a press or a release (legal range 2..15).
- REPEAT_TICKS, 32: ticks between auto-repeat pulses; used only with KEY_REPEAT_EN (legal range 2..255).

Ports:
- CLK  input  1  system clock.
- Reset  input  1  asynchronous, active-low reset.
- ScanEnable  input  1  one-CLK scan tick; consecutive ticks must be at least 4 CLK apart.
- Rows  input  4  keypad rows, active-low, externally pulled up, asynchronous to CLK.
- Cols  output  4  column drive, active-low one-hot.
- KeyCode  output  4  {row_idx[1:0], col_idx[1:0]} of the accepted key.
- KeyValid  output  1  one-CLK pulse when KeyCode is newly valid.
- KeyHeld  output  1  high while the accepted key is held down.

Behaviour:
- Reset (Reset=0, async): Cols=4'b1110, KeyCode=0, KeyValid=0, KeyHeld=0, state=SCAN, col_idx=0, debounce count=0.
- Rows pass through a 2-flop synchronizer. All decisions use the synchronized value, and only on cycles with ScanEnable=1. All outputs are registered.
- Row pattern "active" means any synchronized row bit is 0. If more than one row is low, the lowest-index low row gives row_idx. The stored pattern is the full 4-bit vector.
- SCAN:
  - On a tick with all rows high: col_idx increments modulo 4 and Cols rotates 1110→1101→1011→0111→1110.
  - On a tick with a row active: capture the pattern and row_idx, set count=1, go to PRESS_DB. Cols stays on the current column.
- PRESS_DB, on each tick:
  - Pattern equals capture: count+1.
  - Pattern differs, or all rows high: count cleared, back to SCAN without advancing the column, no output.
  - count reaches DEBOUNCE_TICKS: KeyCode<={row_idx,col_idx}, KeyValid=1 for exactly the next CLK, KeyHeld<=1, go to HOLD.
- HOLD:
  - Cols remains frozen.
  - On a tick with all rows high: count=1, go to REL_DB.
  - Other pattern changes while any row is still low are ignored (no second key, no roll-over).
- REL_DB, on each tick:
  - All rows high: count+1.
  - Any row low: back to HOLD, KeyHeld stays 1, no KeyValid.
  - count reaches DEBOUNCE_TICKS: KeyHeld<=0, advance to the next column, go to SCAN.
- Without ticks, no state changes. KeyValid never pulses twice for one press.
- KeyCode holds its last value until the next accepted press.
- Latency from press to KeyValid: DEBOUNCE_TICKS ticks after the first tick that sees the press, plus 1 CLK. Ticks can see a press at most 2 CLK after the pin changes (synchronizer delay).
- A Reset assertion mid-press forces the reset values immediately. After release of reset, a key still held is re-detected and re-reported as a new press.

Optional Feature:
- KEY_REPEAT_EN defined:
  - In HOLD, a repeat counter counts ticks from entry.
  - Every REPEAT_TICKS ticks, KeyValid pulses again for 1 CLK with KeyCode unchanged.
  - The counter is cleared on leaving HOLD. Ticks spent in REL_DB do not count, and a bounce back to HOLD restarts the count at 0.
- KEY_REPEAT_EN undefined: exactly one KeyValid per press; REPEAT_TICKS is unused and no repeat counter is synthesized.

Test Plan:
- Reset then free-run with ScanEnable every 4 CLK and no key pressed -> Cols cycles 1110,1101,1011,0111,1110 one step per tick; KeyValid never asserts.
- Hold row 2 low only while Cols=1011 (col 2), stable 10 ticks -> exactly one KeyValid pulse, KeyCode=4'b1010, KeyHeld=1, Cols frozen at 1011.
- Bounce: row 1 low for 2 ticks, then high 1 tick, then low again, with DEBOUNCE_TICKS=4 -> no KeyValid until 4 consecutive stable ticks; then one pulse only.
- Release with a 1-tick re-contact during REL_DB -> KeyHeld stays 1, no extra KeyValid; after 4 clean high ticks KeyHeld=0 and Cols advances one column.
- Rows 1 and 3 low together on col 0 -> KeyCode=4'b0100 (row 1 wins).
- Reset asserted mid-HOLD -> outputs immediately at reset values. With KEY_REPEAT_EN and REPEAT_TICKS=8, holding the key 30 ticks after acceptance -> 1+3 KeyValid pulses, all with the same code.
